// File: rtl/lc3b_mem_responder.sv
// LC-3b memory responder: a word array behind a fixed-latency read/write
// handshake, with a sticky flag for initiator protocol violations.
module lc3b_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_wdata,
    input  logic [1:0]  mem_byte_enable,
    output logic        mem_resp,
    output logic [15:0] mem_rdata,
    output logic        mem_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [1:0]    be_q, be_d;
    logic          is_wr_q, is_wr_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          req;
    logic          commit;
    logic          c_wr;
    logic [AW-1:0] c_idx;
    logic [15:0]   c_wdata;
    logic [1:0]    c_be;
    logic [15:0]   addr_unused;

    logic [15:0] mem_array [DEPTH_WORDS] = '{default: 16'h0000};

    assign req         = mem_read | mem_write;
    assign addr_unused = mem_address;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        is_wr_d = is_wr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;
        c_wr    = is_wr_q;
        c_idx   = idx_q;
        c_wdata = wdata_q;
        c_be    = be_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = mem_address[AW:1];
                    wdata_d = mem_wdata;
                    be_d    = mem_byte_enable;
                    is_wr_d = mem_write;
                    if (mem_read && mem_write) err_d = 1'b1;
                    // Single-cycle latency commits straight from the live inputs.
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        commit  = 1'b1;
                        c_wr    = mem_write;
                        c_idx   = mem_address[AW:1];
                        c_wdata = mem_wdata;
                        c_be    = mem_byte_enable;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    err_d   = 1'b1;
                end else if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (commit && !c_wr) rdata_d = mem_array[c_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 16'h0000;
            be_q    <= 2'b00;
            is_wr_q <= 1'b0;
            rdata_q <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            is_wr_q <= is_wr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array is deliberately outside the reset domain; contents survive rst.
    always_ff @(posedge clk) begin
        if (commit && c_wr && !rst) begin
            if (c_be[0]) mem_array[c_idx][7:0]  <= c_wdata[7:0];
            if (c_be[1]) mem_array[c_idx][15:8] <= c_wdata[15:8];
        end
    end

    assign mem_resp  = (state_q == RESP);
    assign mem_rdata = rdata_q;
    assign mem_err   = err_q;
endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Scoreboard bench: three responders (LATENCY 3, 1, 15) driven one at a time;
// expected read data is queued at issue and compared when mem_resp arrives.
module tb_lc3b_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a [3];
    logic        rd_a  [3];
    logic        wr_a  [3];
    logic [15:0] ad_a  [3];
    logic [15:0] wd_a  [3];
    logic [1:0]  be_a  [3];
    logic [2:0]        resp_v;
    logic [2:0]        err_v;
    logic [2:0][15:0]  rdata_v;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        lc3b_mem_responder #(
            .DEPTH_WORDS(256),
            .LATENCY(g == 0 ? 3 : (g == 1 ? 1 : 15))
        ) u_dut (
            .clk(clk),
            .rst(rst_a[g]),
            .mem_read(rd_a[g]),
            .mem_write(wr_a[g]),
            .mem_address(ad_a[g]),
            .mem_wdata(wd_a[g]),
            .mem_byte_enable(be_a[g]),
            .mem_resp(resp_v[g]),
            .mem_rdata(rdata_v[g]),
            .mem_err(err_v[g])
        );
    end

    int n_chk = 0;
    int n_err = 0;
    logic [15:0] mdl [3][256];
    logic [15:0] last_rd [3];
    logic [15:0] sbq [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 3 : ((d == 1) ? 1 : 15);
    endfunction

    // One full transaction; checks latency, read data / hold, and pulse width.
    task automatic xact(input int d, input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] wd, input logic [1:0] be);
        int c;
        logic [7:0] ix;
        logic [15:0] e;
        ix = a[8:1];
        if (r && !w) sbq.push_back(mdl[d][ix]);
        if (w) begin
            if (be[0]) mdl[d][ix][7:0]  = wd[7:0];
            if (be[1]) mdl[d][ix][15:8] = wd[15:8];
        end
        rd_a[d] = r; wr_a[d] = w; ad_a[d] = a; wd_a[d] = wd; be_a[d] = be;
        @(posedge clk);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!resp_v[d] && c < 40);
        chk("latency", c, lat_of(d));
        if (resp_v[d] && r && !w && sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("rdata", rdata_v[d], e);
            last_rd[d] = e;
        end else if (resp_v[d]) begin
            chk("rdata_hold", rdata_v[d], last_rd[d]);
        end
        rd_a[d] = 1'b0; wr_a[d] = 1'b0;
        @(negedge clk);
        chk("resp_width", resp_v[d], 1'b0);
    endtask

    task automatic do_reset(input int d);
        rst_a[d] = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_resp", resp_v[d], 1'b0);
        chk("rst_rdata", rdata_v[d], 16'h0000);
        chk("rst_err", err_v[d], 1'b0);
        last_rd[d] = 16'h0000;
        rst_a[d] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_a[d] = 1'b1; rd_a[d] = 1'b0; wr_a[d] = 1'b0;
            ad_a[d] = 16'h0; wd_a[d] = 16'h0; be_a[d] = 2'b00;
            last_rd[d] = 16'h0;
            for (int i = 0; i < 256; i++) mdl[d][i] = 16'h0000;
        end
        @(negedge clk);

        // LATENCY=3: basic, byte masks, wrap, violations, reset mid-write
        do_reset(0);
        xact(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11);
        xact(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00);
        xact(0, 1'b0, 1'b1, 16'h0010, 16'h1234, 2'b01);
        xact(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00);
        xact(0, 1'b0, 1'b1, 16'h0010, 16'h5600, 2'b10);
        xact(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b01);
        xact(0, 1'b0, 1'b1, 16'h0010, 16'hFFFF, 2'b00);
        xact(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00);
        xact(0, 1'b0, 1'b1, 16'h0202, 16'hA5A5, 2'b11);
        xact(0, 1'b1, 1'b0, 16'h0003, 16'h0000, 2'b00);
        chk("err_clean", err_v[0], 1'b0);

        xact(0, 1'b1, 1'b1, 16'h0020, 16'hC0DE, 2'b11);
        chk("err_both", err_v[0], 1'b1);
        xact(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00);

        // Request dropped while BUSY: no response, no write, sticky error
        rd_a[0] = 1'b0; wr_a[0] = 1'b1; ad_a[0] = 16'h0030; wd_a[0] = 16'h1111; be_a[0] = 2'b11;
        @(posedge clk);
        @(negedge clk);
        wr_a[0] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("abort_resp", resp_v[0], 1'b0);
        end
        chk("abort_err", err_v[0], 1'b1);
        xact(0, 1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00);
        chk("err_sticky", err_v[0], 1'b1);

        // Reset while BUSY on a write to 0x0010
        rd_a[0] = 1'b0; wr_a[0] = 1'b1; ad_a[0] = 16'h0010; wd_a[0] = 16'hDEAD; be_a[0] = 2'b11;
        @(posedge clk);
        @(negedge clk);
        rst_a[0] = 1'b1; wr_a[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rstmid_resp", resp_v[0], 1'b0);
        end
        chk("rstmid_rdata", rdata_v[0], 16'h0000);
        chk("rstmid_err", err_v[0], 1'b0);
        rst_a[0] = 1'b0;
        last_rd[0] = 16'h0000;
        xact(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00);

        // Latency sweep on LATENCY=1 and LATENCY=15 instances
        for (int d = 1; d < 3; d++) begin
            do_reset(d);
            xact(d, 1'b0, 1'b1, 16'h0044, 16'h7777, 2'b11);
            xact(d, 1'b1, 1'b0, 16'h0044, 16'h0000, 2'b00);
            xact(d, 1'b0, 1'b1, 16'h0044, 16'h1234, 2'b10);
            xact(d, 1'b1, 1'b0, 16'h0044, 16'h0000, 2'b00);
            chk("sweep_err", err_v[d], 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
